// File: rtl/bdb_debounce_counter.sv
// Purpose: debounces an asynchronous button and counts accepted presses. Each press posts a result record with a valid/ready handshake.
// Latency: debounced changes DEBOUNCE_CYCLES+1 edges after the first edge that samples a clean new level. The count and record update on that same edge.
// Backpressure: a press that arrives while a record is still pending overwrites that record and flags overrun; presses are never stalled.
`timescale 1ns/1ps
module bdb_debounce_counter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   button_raw,
    output logic                   debounced,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic                   result_overrun
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam logic [15:0]            STAB_LIMIT = 16'(DEBOUNCE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    logic                   sync_meta;
    logic                   sync;
    state_t                 state;
    state_t                 state_next;
    logic [15:0]            stab;
    logic [15:0]            stab_next;
    logic [15:0]            stab_inc;
    logic                   press;
    logic [COUNT_WIDTH-1:0] count_inc;

    assign stab_inc  = stab + 16'd1;
    assign count_inc = count + COUNT_ONE;
    assign debounced = (state == STABLE_HIGH) || (state == WAIT_LOW);

    // Two-flop synchronizer. Only sync is allowed to reach the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= button_raw;
            sync      <= sync_meta;
        end
    end

    // Debounce FSM state and stability counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= STABLE_LOW;
            stab  <= 16'd0;
        end else begin
            state <= state_next;
            stab  <= stab_next;
        end
    end

    // Next-state logic. A single sample at the old level during a WAIT state rejects the bounce.
    always_comb begin
        state_next = state;
        stab_next  = stab;
        press      = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (sync) begin
                    state_next = WAIT_HIGH;
                    stab_next  = 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (!sync) begin
                    state_next = STABLE_LOW;
                    stab_next  = 16'd0;
                end else if (stab_inc == STAB_LIMIT) begin
                    state_next = STABLE_HIGH;
                    stab_next  = 16'd0;
                    press      = 1'b1;
                end else begin
                    stab_next  = stab_inc;
                end
            end
            STABLE_HIGH: begin
                if (!sync) begin
                    state_next = WAIT_LOW;
                    stab_next  = 16'd1;
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_next = STABLE_HIGH;
                    stab_next  = 16'd0;
                end else if (stab_inc == STAB_LIMIT) begin
                    state_next = STABLE_LOW;
                    stab_next  = 16'd0;
                end else begin
                    stab_next  = stab_inc;
                end
            end
            default: begin
                state_next = STABLE_LOW;
                stab_next  = 16'd0;
            end
        endcase
    end

    // Press counter. It wraps naturally at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (press) begin
            count <= count_inc;
        end
    end

    // Result record. A press always wins. Overrun is set only if the record it replaces was never accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_valid   <= 1'b0;
            result_count   <= '0;
            result_overrun <= 1'b0;
        end else if (press) begin
            result_valid   <= 1'b1;
            result_count   <= count_inc;
            result_overrun <= result_valid && !result_ready;
        end else if (result_valid && result_ready) begin
            result_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bdb_debounce_counter.sv
// Directed testbench for bdb_debounce_counter, using DEBOUNCE_CYCLES=4.
// The main instance uses an 8-bit counter. A second instance uses a 2-bit counter to exercise wrap.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_bdb_debounce_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       button_raw = 1'b0;
    logic       result_ready = 1'b0;
    logic       debounced;
    logic [7:0] count;
    logic       result_valid;
    logic [7:0] result_count;
    logic       result_overrun;

    logic       w_raw = 1'b0;
    logic       w_ready = 1'b1;
    logic       w_debounced;
    logic [1:0] w_count;
    logic       w_valid;
    logic [1:0] w_result_count;
    logic       w_overrun;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bdb_debounce_counter #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .button_raw     (button_raw),
        .debounced      (debounced),
        .count          (count),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_count   (result_count),
        .result_overrun (result_overrun)
    );

    bdb_debounce_counter #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(2)) u_wrap (
        .clk            (clk),
        .reset_n        (reset_n),
        .button_raw     (w_raw),
        .debounced      (w_debounced),
        .count          (w_count),
        .result_valid   (w_valid),
        .result_ready   (w_ready),
        .result_count   (w_result_count),
        .result_overrun (w_overrun)
    );

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Full press-and-release on the main instance. It leaves the FSM back in STABLE_LOW.
    task automatic press_release();
        button_raw = 1'b1;
        repeat (8) @(negedge clk);
        button_raw = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({debounced, count, result_valid, result_count, result_overrun} !== 19'd0) begin
            fails++;
            $display("FAIL reset_main: got dbn=%b cnt=%0d vld=%b rc=%0d ovr=%b, want all 0",
                     debounced, count, result_valid, result_count, result_overrun);
        end
        checks++;
        if ({w_debounced, w_count, w_valid, w_result_count, w_overrun} !== 7'd0) begin
            fails++;
            $display("FAIL reset_wrap: got dbn=%b cnt=%0d vld=%b, want all 0", w_debounced, w_count, w_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_clean_press();
        do_reset();
        result_ready = 1'b1;
        button_raw   = 1'b1;
        repeat (5) @(negedge clk);   // after edges 0..4
        checks++;
        if (debounced !== 1'b0 || count !== 8'd0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL clean_before_e5: dbn=%b cnt=%0d vld=%b, want 0 0 0", debounced, count, result_valid);
        end
        @(negedge clk);              // after edge 5
        checks++;
        if (debounced !== 1'b1 || count !== 8'd1) begin
            fails++;
            $display("FAIL clean_e5: dbn=%b cnt=%0d, want 1 1", debounced, count);
        end
        checks++;
        if (result_valid !== 1'b1 || result_count !== 8'd1 || result_overrun !== 1'b0) begin
            fails++;
            $display("FAIL clean_record: vld=%b rc=%0d ovr=%b, want 1 1 0", result_valid, result_count, result_overrun);
        end
        @(negedge clk);              // the record was accepted on edge 6
        checks++;
        if (result_valid !== 1'b0) begin
            fails++;
            $display("FAIL clean_accept: vld=%b, want 0", result_valid);
        end
        button_raw = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (debounced !== 1'b1) begin
            fails++;
            $display("FAIL release_latency_early: dbn=%b, want 1", debounced);
        end
        @(negedge clk);
        checks++;
        if (debounced !== 1'b0 || count !== 8'd1 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL release: dbn=%b cnt=%0d vld=%b, want 0 1 0", debounced, count, result_valid);
        end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        do_reset();
        result_ready = 1'b1;
        button_raw = 1'b1;
        repeat (3) @(negedge clk);
        if (debounced !== 1'b0) bad++;
        button_raw = 1'b0;
        @(negedge clk);
        if (debounced !== 1'b0) bad++;
        button_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin  // after edges 4..8
            @(negedge clk);
            if (debounced !== 1'b0 || count !== 8'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bounce_glitch: %0d samples changed output, want 0", bad);
        end
        @(negedge clk);                     // after edge 9
        checks++;
        if (debounced !== 1'b1 || count !== 8'd1) begin
            fails++;
            $display("FAIL bounce_accept: dbn=%b cnt=%0d, want 1 1", debounced, count);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (count !== 8'd1) begin
            fails++;
            $display("FAIL bounce_single: cnt=%0d, want 1", count);
        end
        button_raw = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        result_ready = 1'b0;
        repeat (3) press_release();
        checks++;
        if (result_valid !== 1'b1 || result_count !== 8'd3 || result_overrun !== 1'b1) begin
            fails++;
            $display("FAIL bp_three: vld=%b rc=%0d ovr=%b, want 1 3 1", result_valid, result_count, result_overrun);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: vld=%b, want 0", result_valid);
        end
        press_release();
        checks++;
        if (result_valid !== 1'b1 || result_count !== 8'd4 || result_overrun !== 1'b0) begin
            fails++;
            $display("FAIL bp_fourth: vld=%b rc=%0d ovr=%b, want 1 4 0", result_valid, result_count, result_overrun);
        end
    endtask

    task automatic test_simultaneous();
        result_ready = 1'b0;
        press_release();             // 5th press overwrites the pending record
        checks++;
        if (result_count !== 8'd5 || result_overrun !== 1'b1) begin
            fails++;
            $display("FAIL sim_setup: rc=%0d ovr=%b, want 5 1", result_count, result_overrun);
        end
        button_raw = 1'b1;
        repeat (5) @(negedge clk);
        result_ready = 1'b1;         // ready lands on the press edge
        @(negedge clk);
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result_count !== 8'd6 || result_overrun !== 1'b0 || count !== 8'd6) begin
            fails++;
            $display("FAIL sim_accept_press: vld=%b rc=%0d ovr=%b cnt=%0d, want 1 6 0 6",
                     result_valid, result_count, result_overrun, count);
        end
        button_raw = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [5];
        int bad;
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bad = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w_raw = 1'b1;
            repeat (8) @(negedge clk);
            if (w_count !== exp_seq[i]) begin
                bad++;
                $display("FAIL wrap_press%0d: cnt=%0d, want %0d", i + 1, w_count, exp_seq[i]);
            end
            w_raw = 1'b0;
            repeat (8) @(negedge clk);
        end
        checks++;
        if (bad != 0) fails++;
        checks++;
        if (w_overrun !== 1'b0 || w_result_count !== 2'd1) begin
            fails++;
            $display("FAIL wrap_record: rc=%0d ovr=%b, want 1 0", w_result_count, w_overrun);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        result_ready = 1'b0;
        press_release();             // leaves a pending record, count=1
        button_raw = 1'b1;
        repeat (3) @(negedge clk);   // in WAIT_HIGH
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({debounced, count, result_valid, result_count, result_overrun} !== 19'd0) begin
            fails++;
            $display("FAIL rst_async: dbn=%b cnt=%0d vld=%b rc=%0d ovr=%b, want all 0",
                     debounced, count, result_valid, result_count, result_overrun);
        end
        @(negedge clk);
        reset_n = 1'b1;              // raw remains high
        repeat (5) @(negedge clk);
        checks++;
        if (debounced !== 1'b0 || count !== 8'd0) begin
            fails++;
            $display("FAIL rst_latency_early: dbn=%b cnt=%0d, want 0 0", debounced, count);
        end
        @(negedge clk);
        checks++;
        if (debounced !== 1'b1 || count !== 8'd1 || result_valid !== 1'b1 ||
            result_count !== 8'd1 || result_overrun !== 1'b0) begin
            fails++;
            $display("FAIL rst_repress: dbn=%b cnt=%0d vld=%b rc=%0d ovr=%b, want 1 1 1 1 0",
                     debounced, count, result_valid, result_count, result_overrun);
        end
        button_raw = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_backpressure();
        test_simultaneous();
        test_wrap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
